fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_pkg.sv | 13 +
 rtl/fetch_queue.sv | 108 ++++++++++
 tb/tb_fetch_queue.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types for the instruction fetch queue: the instruction word and
// the queue's control-state encoding.
package Types;

  typedef logic [31:0] word;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } fq_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Dual-issue instruction fetch queue: requests bundles from ROM, buffers them
// in a circular FIFO and presents up to two program-ordered words to decode.
module fetch_queue
  import Types::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  output logic                     o_fetch_en,
  input  word                      i_insts [0:1],
  output word                      o_insts [0:1],
  output logic [1:0]               o_valid,
  input  logic                     i_deq_ready,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  word             mem_reg [DEPTH];
  logic [AW-1:0]   head_reg, head_next;
  logic [AW-1:0]   tail_reg, tail_next;
  logic [AW-1:0]   head_p1, tail_p1;
  logic [CW-1:0]   count_reg, count_next;
  logic            inflight_reg;
  fq_state_e       state_reg, state_next;

  logic            sample;
  logic            eof;
  logic            room;
  logic            fetch_en;
  logic [1:0]      enq_n;
  logic [1:0]      deq_n;

  assign head_p1 = head_reg + AW'(1);
  assign tail_p1 = tail_reg + AW'(1);

  // ROM data is only meaningful the cycle after a request, and only while
  // the program has not yet ended.
  assign sample = inflight_reg && (state_reg == FETCH);
  assign eof    = sample && ((i_insts[0] == '0) || (i_insts[1] == '0));

  always_comb begin
    enq_n = 2'd0;
    if (sample && (i_insts[0] != '0)) begin
      enq_n = (i_insts[1] != '0) ? 2'd2 : 2'd1;
    end
  end

  assign deq_n = !i_deq_ready          ? 2'd0 :
                 (count_reg >= CW'(2)) ? 2'd2 : {1'b0, count_reg[0]};

  // Reserve space for the bundle already in flight plus the one requested now.
  assign room = (int'(count_reg) + (inflight_reg ? 2 : 0) + 2) <= DEPTH;

  // Suppressing the request on the end-of-program sample means no bundle
  // can still be outstanding once the queue is draining.
  assign fetch_en   = (state_reg == FETCH) && room && !eof;
  assign o_fetch_en = fetch_en && i_rst_n;

  assign head_next  = head_reg + AW'(deq_n);
  assign tail_next  = tail_reg + AW'(enq_n);
  assign count_next = count_reg + CW'(enq_n) - CW'(deq_n);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH:   if (eof) state_next = DRAIN;
      DRAIN:   if (count_reg == '0) state_next = DONE;
      default: state_next = DONE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      inflight_reg <= 1'b0;
      state_reg    <= FETCH;
    end else begin
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      count_reg    <= count_next;
      inflight_reg <= fetch_en;
      state_reg    <= state_next;
    end
  end

  // Storage carries no reset; validity comes solely from count_reg.
  always_ff @(posedge i_clk) begin
    if (enq_n != 2'd0) mem_reg[tail_reg] <= i_insts[0];
    if (enq_n == 2'd2) mem_reg[tail_p1]  <= i_insts[1];
  end

  assign o_valid[0] = (count_reg >= CW'(1));
  assign o_valid[1] = (count_reg >= CW'(2));
  assign o_insts[0] = o_valid[0] ? mem_reg[head_reg] : '0;
  assign o_insts[1] = o_valid[1] ? mem_reg[head_p1]  : '0;
  assign o_count    = count_reg;
  assign o_done     = (state_reg == DONE);

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    count_reg <= CW'(DEPTH));

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised bench for fetch_queue: a ROM model feeds bundles and a queue-based
// reference model predicts every output each cycle.
module tb_fetch_queue;
  import Types::*;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fetch_en;
  logic          deq_ready = 1'b0;
  word           insts_in  [0:1];
  word           insts_out [0:1];
  logic [1:0]    valid;
  logic [CW-1:0] count;
  logic          done;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .o_fetch_en  (fetch_en),
    .i_insts     (insts_in),
    .o_insts     (insts_out),
    .o_valid     (valid),
    .i_deq_ready (deq_ready),
    .o_count     (count),
    .o_done      (done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: program-ordered word queue plus a handful of flags.
  word mq[$];
  bit  m_inflight = 0;
  int  m_state = 0;          // 0 fetching, 1 draining, 2 done
  bit  rom_pending = 0;
  bit  stale = 0;
  int  rom_mode = 0;         // 0 fixed bundle, 1 random nonzero words
  word prog0[$], prog1[$];
  int  cyc = 0;

  function automatic word rnd_word();
    return $urandom | 32'h1;
  endfunction

  task automatic cycle(input bit rdy);
    bit eof, fetch;
    int n0, npop;
    @(negedge clk);
    deq_ready = rdy;
    if (stale) begin
      insts_in[0] = 32'h00500113;
      insts_in[1] = 32'h00500113;
      stale = 0;
    end else if (rom_pending) begin
      if (prog0.size() > 0) begin
        insts_in[0] = prog0.pop_front();
        insts_in[1] = prog1.pop_front();
      end else if (rom_mode == 0) begin
        insts_in[0] = 32'h00000013;
        insts_in[1] = 32'h00100093;
      end else begin
        insts_in[0] = rnd_word();
        insts_in[1] = rnd_word();
      end
    end else begin
      insts_in[0] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      insts_in[1] = $urandom;
    end
    #1;
    eof   = rst_n && (m_state == 0) && m_inflight &&
            ((insts_in[0] == 32'h0) || (insts_in[1] == 32'h0));
    fetch = rst_n && (m_state == 0) && !eof &&
            (mq.size() + 2 * int'(m_inflight) + 2 <= DEPTH);
    check("fetch_en", fetch_en, fetch);
    check("valid", valid, {mq.size() >= 2, mq.size() >= 1});
    check("inst0", insts_out[0], (mq.size() >= 1) ? mq[0] : 32'h0);
    check("inst1", insts_out[1], (mq.size() >= 2) ? mq[1] : 32'h0);
    check("count", count, mq.size());
    check("done", done, m_state == 2);
    $display("cyc %0d rst_n=%0b rdy=%0b fetch=%0b in=%08h/%08h valid=%b out=%08h/%08h count=%0d done=%0b",
             cyc, rst_n, rdy, fetch_en, insts_in[0], insts_in[1], valid,
             insts_out[0], insts_out[1], count, done);
    cyc++;
    rom_pending = fetch_en;
    if (!rst_n) begin
      mq.delete();
      m_inflight = 0;
      m_state    = 0;
    end else begin
      n0   = mq.size();
      npop = rdy ? ((n0 < 2) ? n0 : 2) : 0;
      repeat (npop) void'(mq.pop_front());
      if (m_inflight && m_state == 0 && insts_in[0] != 32'h0) begin
        mq.push_back(insts_in[0]);
        if (insts_in[1] != 32'h0) mq.push_back(insts_in[1]);
      end
      if (m_state == 0 && eof)       m_state = 1;
      else if (m_state == 1 && n0 == 0) m_state = 2;
      m_inflight = fetch;
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_fetch", fetch_en, 1'b0);
    check("rst_valid", valid, 2'b00);
    check("rst_inst0", insts_out[0], 32'h0);
    check("rst_inst1", insts_out[1], 32'h0);
    check("rst_count", count, 0);
    check("rst_done", done, 1'b0);
    mq.delete();
    m_inflight = 0;
    m_state    = 0;
    cyc        = 0;
    cycle(1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stale = 1;
  endtask

  task automatic push_bundle(input word w0, input word w1);
    prog0.push_back(w0);
    prog1.push_back(w1);
  endtask

  initial begin
    int first_fetch, first_valid, pairs, max_cnt;
    bit saw_fetch;
    insts_in[0] = 32'h0;
    insts_in[1] = 32'h0;

    // Startup latency and steady two-word streaming.
    cycle(1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    first_fetch = -1;
    first_valid = -1;
    pairs = 0;
    for (int c = 1; c <= 40; c++) begin
      cycle(1'b1);
      if (first_fetch < 0 && fetch_en)      first_fetch = c;
      if (first_valid < 0 && valid == 2'b11) first_valid = c;
      if (c >= 3 && valid == 2'b11)          pairs++;
    end
    check("first_fetch_cycle", first_fetch, 1);
    check("first_valid_cycle", first_valid, 3);
    check("steady_pairs", pairs, 38);

    // Back-pressure fills the queue exactly, then release resumes fetching.
    max_cnt = 0;
    repeat (20) begin
      cycle(1'b0);
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
    check("full_count", count, DEPTH);
    check("full_no_fetch", fetch_en, 1'b0);
    check("full_max", max_cnt, DEPTH);
    saw_fetch = 0;
    repeat (20) begin
      cycle(1'b1);
      if (fetch_en) saw_fetch = 1;
    end
    check("fetch_resumes", saw_fetch, 1'b1);

    // Random words under random back-pressure, ended by a random EOF bundle.
    rom_mode = 1;
    repeat (300) cycle(1'($urandom_range(0, 1)));
    if ($urandom_range(0, 1) == 0) push_bundle(rnd_word(), 32'h0);
    else                           push_bundle(32'h0, rnd_word());
    for (int i = 0; i < 200 && !done; i++) cycle(1'($urandom_range(0, 1)));
    check("rand_done", done, 1'b1);

    // Second slot zero: one word enqueued, then drain to done.
    pulse_reset();
    rom_mode = 0;
    push_bundle(32'h00000013, 32'h00100093);
    push_bundle(32'h00500113, 32'h00000000);
    repeat (10) cycle(1'b0);
    check("eof1_count", count, 3);
    check("eof1_fetch", fetch_en, 1'b0);
    check("eof1_done", done, 1'b0);
    for (int i = 0; i < 20 && !done; i++) cycle(1'b1);
    check("eof1_done_end", done, 1'b1);
    check("eof1_empty", count, 0);

    // First slot zero: nothing enqueued, prior entries drain, then done.
    pulse_reset();
    push_bundle(32'h00000013, 32'h00100093);
    push_bundle(32'h00000013, 32'h00100093);
    push_bundle(32'h00000000, 32'h00500113);
    repeat (10) cycle(1'b0);
    check("eof0_count", count, 4);
    check("eof0_fetch", fetch_en, 1'b0);
    for (int i = 0; i < 20 && !done; i++) cycle(1'b1);
    check("eof0_done_end", done, 1'b1);

    // Reset with five words queued; stale ROM data afterwards is ignored.
    pulse_reset();
    push_bundle(32'h00000013, 32'h00100093);
    push_bundle(32'h00000013, 32'h00100093);
    push_bundle(32'h00500113, 32'h00000000);
    repeat (10) cycle(1'b0);
    check("pre_rst_count", count, 5);
    pulse_reset();
    cycle(1'b1);
    check("post_rst_fetch", fetch_en, 1'b1);
    check("post_rst_count", count, 0);
    repeat (15) cycle(1'b1);
    check("post_rst_stream", valid, 2'b11);

    // Reset while fetches are outstanding.
    repeat (5) cycle(1'b0);
    pulse_reset();
    repeat (20) cycle(1'($urandom_range(0, 1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
